// File: rtl/hazard_ctrl_p_if.sv
// rtl/hazard_ctrl_p_if.sv - pipeline hazard controller signal bundle
interface hazard_ctrl_p_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic              mem_en_ID_EX;
    logic              mem_wr_ID_EX;
    logic [REG_AW-1:0] w1_reg_ID_EX;
    logic [REG_AW-1:0] read_reg1;
    logic [REG_AW-1:0] read_reg2;
    logic              rd1_used;
    logic              rd2_used;
    logic              reg_en;
    logic              mem_en;
    logic              mem_wr;
    logic              mem_busy;
    logic              mem_done;
    logic              branch_taken;
    logic              cnt_clr;
    logic              reg_en_f;
    logic              mem_en_f;
    logic              mem_wr_f;
    logic              pause_pc;
    logic              wrt_IF_ID;
    logic              flush_IF_ID;
    logic              freeze_pipe;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output mem_en_ID_EX, mem_wr_ID_EX, w1_reg_ID_EX, read_reg1, read_reg2,
               rd1_used, rd2_used, reg_en, mem_en, mem_wr, mem_busy, mem_done,
               branch_taken, cnt_clr,
        input  reg_en_f, mem_en_f, mem_wr_f, pause_pc, wrt_IF_ID, flush_IF_ID,
               freeze_pipe, stall_cycles
    );

    modport slave (
        input  mem_en_ID_EX, mem_wr_ID_EX, w1_reg_ID_EX, read_reg1, read_reg2,
               rd1_used, rd2_used, reg_en, mem_en, mem_wr, mem_busy, mem_done,
               branch_taken, cnt_clr,
        output reg_en_f, mem_en_f, mem_wr_f, pause_pc, wrt_IF_ID, flush_IF_ID,
               freeze_pipe, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_p.sv
// rtl/hazard_ctrl_p.sv - load-use / cache-miss / branch hazard controller
module hazard_ctrl_p #(
    parameter int REG_AW     = 3,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    hazard_ctrl_p_if.slave hz
);
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       bub_q, bub_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_AW-1:0] w1, r1, r2;
    logic              hazard;
    logic              br_any;

    assign w1     = hz.w1_reg_ID_EX;
    assign r1     = hz.read_reg1;
    assign r2     = hz.read_reg2;
    assign hazard = hz.mem_en_ID_EX & ~hz.mem_wr_ID_EX &
                    ((hz.rd1_used & (w1 == r1)) | (hz.rd2_used & (w1 == r2)));
    // A branch seen while frozen is replayed as a flush on the first free cycle
    assign br_any = hz.branch_taken | br_q;

    always_comb begin
        state_d        = state_q;
        bub_d          = bub_q;
        br_d           = br_q;
        hz.reg_en_f    = hz.reg_en;
        hz.mem_en_f    = hz.mem_en;
        hz.mem_wr_f    = hz.mem_wr;
        hz.pause_pc    = 1'b0;
        hz.wrt_IF_ID   = 1'b1;
        hz.flush_IF_ID = 1'b0;
        hz.freeze_pipe = 1'b0;

        case (state_q)
            MEM_WAIT: begin
                hz.freeze_pipe = 1'b1;
                hz.pause_pc    = 1'b1;
                hz.wrt_IF_ID   = 1'b0;
                br_d           = br_any;
                if (hz.mem_done) begin
                    state_d = (bub_q != 3'd0) ? LU_STALL : RUN;
                end
            end
            default: begin
                if (hz.mem_busy) begin
                    hz.freeze_pipe = 1'b1;
                    hz.pause_pc    = 1'b1;
                    hz.wrt_IF_ID   = 1'b0;
                    if (state_q == LU_STALL) begin
                        hz.reg_en_f = 1'b0;
                        hz.mem_en_f = 1'b0;
                        hz.mem_wr_f = 1'b0;
                    end
                    br_d    = br_any;
                    state_d = MEM_WAIT;
                end else if (br_any) begin
                    hz.flush_IF_ID = 1'b1;
                    br_d           = 1'b0;
                    bub_d          = 3'd0;
                    state_d        = RUN;
                end else if (state_q == LU_STALL || hazard) begin
                    hz.reg_en_f  = 1'b0;
                    hz.mem_en_f  = 1'b0;
                    hz.mem_wr_f  = 1'b0;
                    hz.pause_pc  = 1'b1;
                    hz.wrt_IF_ID = 1'b0;
                    if (state_q == LU_STALL) begin
                        bub_d   = bub_q - 3'd1;
                        state_d = (bub_q == 3'd1) ? RUN : LU_STALL;
                    end else if (LU_BUBBLES > 1) begin
                        bub_d   = 3'(LU_BUBBLES - 1);
                        state_d = LU_STALL;
                    end
                end
            end
        endcase

        if (rst) begin
            hz.reg_en_f    = 1'b0;
            hz.mem_en_f    = 1'b0;
            hz.mem_wr_f    = 1'b0;
            hz.pause_pc    = 1'b1;
            hz.wrt_IF_ID   = 1'b0;
            hz.flush_IF_ID = 1'b0;
            hz.freeze_pipe = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hz.cnt_clr) begin
            cnt_d = '0;
        end else if (hz.pause_pc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            bub_q   <= 3'd0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stall_cycles = cnt_q;
endmodule
